// File: rtl/sha1_arbiter_if.sv
// sha1_arbiter_if: request and response channels between the block producers and the sha1 arbiter
interface sha1_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*512-1:0] req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [159:0]           rsp_digest;
    logic                   rsp_error;
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_digest, rsp_error
    );
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_digest, rsp_error
    );
endinterface

// File: rtl/sha1_arbiter.sv
// sha1_arbiter: round-robin front-end sharing one sha1 core among NUM_REQ requesters.
// Define SHA1_ARB_TIMEOUT_EN to add the RUN-state watchdog that aborts and resets a stuck core.
module sha1_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DRAIN_CYCLES = 2
`ifdef SHA1_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1023
`endif
) (
    input  logic          clk,
    input  logic          reset,
    sha1_arbiter_if.slave bus,
    output logic          core_rst,
    output logic          core_on,
    output logic [511:0]  core_msg,
    input  logic [159:0]  core_digest,
    input  logic          core_finish,
    output logic          busy
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr, grant, cand, id_reg;
    logic           found, abort, err, drain_done;
    logic [159:0]   digest_reg;
    logic [DCW-1:0] drain_cnt;

    // Search starts just after the last granted requester and wraps.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign bus.req_ready = (state == IDLE && found && !reset) ? (NUM_REQ'(1) << grant) : '0;
    assign busy          = state != IDLE;
    assign drain_done    = drain_cnt == DCW'(DRAIN_CYCLES - 1);

    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? RUN : IDLE;
            RUN:     state_nx = (core_finish || abort) ? DRAIN : RUN;
            DRAIN:   state_nx = drain_done ? RESP : DRAIN;
            RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr         <= IDW'(NUM_REQ - 1);
            id_reg         <= '0;
            core_msg       <= '0;
            core_on        <= 1'b0;
            digest_reg     <= '0;
            drain_cnt      <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_digest <= '0;
            bus.rsp_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    core_msg <= bus.req_data[int'(grant)*512 +: 512];
                    id_reg   <= grant;
                    rr_ptr   <= grant;
                    core_on  <= 1'b1;
                end
                RUN: if (core_finish || abort) begin
                    digest_reg <= core_finish ? core_digest : '0;
                    core_on    <= 1'b0;
                    drain_cnt  <= '0;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DCW'(1);
                    if (drain_done) begin
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_id     <= id_reg;
                        bus.rsp_digest <= digest_reg;
                        bus.rsp_error  <= err;
                    end
                end
                RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef SHA1_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;
    logic          abort_q;

    // A finish arriving on the expiry cycle takes priority over the abort.
    assign abort    = state == RUN && !core_finish && timer == TW'(TIMEOUT_CYCLES - 1);
    assign core_rst = reset | abort_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer   <= '0;
            abort_q <= 1'b0;
            err     <= 1'b0;
        end else begin
            abort_q <= abort;
            timer   <= (state == RUN) ? timer + TW'(1) : '0;
            err     <= abort | (err & !(state == RUN && core_finish));
        end
    end
`else
    assign abort    = 1'b0;
    assign err      = 1'b0;
    assign core_rst = reset;
`endif
endmodule

// File: tb/tb_sha1_arbiter.sv
// tb_sha1_arbiter: randomized and directed checks of sha1_arbiter against a queue-based round-robin model
module tb_sha1_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         core_rst, core_on, core_finish, busy, hang;
    logic [511:0] core_msg;
    logic [159:0] core_digest;
    int           on_cnt;
    int           cmp = 0;
    int           errs = 0;

    sha1_arbiter_if #(.NUM_REQ(N)) bus ();

    always #5 clk = ~clk;

    sha1_arbiter #(
        .NUM_REQ(N),
        .DRAIN_CYCLES(2)
`ifdef SHA1_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .core_rst(core_rst),
        .core_on(core_on),
        .core_msg(core_msg),
        .core_digest(core_digest),
        .core_finish(core_finish),
        .busy(busy)
    );

    // Core stub: finish 20 cycles after on rises, clears one cycle after on falls.
    always @(posedge clk) begin
        if (core_rst) begin
            on_cnt      <= 0;
            core_finish <= 1'b0;
        end else if (core_on) begin
            on_cnt <= on_cnt + 1;
            if (on_cnt == 19 && !hang) core_finish <= 1'b1;
        end else begin
            on_cnt      <= 0;
            core_finish <= 1'b0;
        end
    end

    assign core_digest = {5{core_msg[31:0]}};

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [159:0] exp_dig(input int i);
        return {5{bus.req_data[i*512 +: 32]}};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        hang = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) bus.req_data[i*512 +: 512] = rnd512();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready(output bit got);
        #1;
        got = bus.req_ready != '0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk); #1;
            got = bus.req_ready != '0;
        end
    endtask

    task automatic wait_rsp(output bit got);
        #1;
        got = bus.rsp_valid === 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk); #1;
            got = bus.rsp_valid === 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hang = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) bus.req_data[i*512 +: 512] = rnd512();
        bus.req_valid = N'($urandom_range(1, 15));
        repeat (3) @(negedge clk);
        #1;
        cmp++; if (bus.req_ready !== '0) begin errs++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
        cmp++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        cmp++; if (bus.rsp_id !== '0) begin errs++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
        cmp++; if (bus.rsp_digest !== '0) begin errs++; $display("FAIL reset_rsp_digest got %h want 0", bus.rsp_digest); end
        cmp++; if (bus.rsp_error !== 1'b0) begin errs++; $display("FAIL reset_rsp_error got %b want 0", bus.rsp_error); end
        cmp++; if (core_on !== 1'b0) begin errs++; $display("FAIL reset_core_on got %b want 0", core_on); end
        cmp++; if (core_msg !== '0) begin errs++; $display("FAIL reset_core_msg got nonzero want 0"); end
        cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        cmp++; if (core_rst !== 1'b1) begin errs++; $display("FAIL reset_core_rst got %b want 1", core_rst); end
        bus.req_valid = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [511:0] blk;
        int k;
        do_reset();
        blk = rnd512();
        blk[31:0] = 32'h12345678;
        bus.req_data[511:0] = blk;
        bus.req_valid = 4'b0001;
        #1;
        cmp++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL single_grant got %b want 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        cmp++; if (core_on !== 1'b1 || bus.req_ready !== '0 || core_msg !== blk) begin
            errs++; $display("FAIL single_start got on=%b ready=%b msg_ok=%b want on=1 ready=0 msg_ok=1", core_on, bus.req_ready, core_msg === blk);
        end
        k = 0;
        while (core_finish !== 1'b1 && k < 100) begin @(negedge clk); #1; k++; end
        cmp++; if (k >= 100) begin errs++; $display("FAIL single_finish got no finish want finish within 100 cycles"); end
        for (k = 0; k < 10 && bus.rsp_valid !== 1'b1; k++) begin @(negedge clk); #1; end
        cmp++; if (k != 3) begin errs++; $display("FAIL single_latency got %0d want 3", k); end
        cmp++; if (bus.rsp_id !== 2'd0 || bus.rsp_digest !== {5{32'h12345678}} || bus.rsp_error !== 1'b0) begin
            errs++; $display("FAIL single_rsp got id=%0d dig=%h err=%b want id=0 dig=%h err=0", bus.rsp_id, bus.rsp_digest, bus.rsp_error, {5{32'h12345678}});
        end
        @(negedge clk); #1;
        cmp++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL single_release got valid=%b busy=%b want 0 0", bus.rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        int order[5];
        int q_id[$];
        logic [159:0] q_dig[$];
        int g = 0;
        int r = 0;
        do_reset();
        bus.req_valid = '1;
        for (int t = 0; t < 400 && r < 5; t++) begin
            #1;
            if (bus.req_ready != '0 && g < 5) begin
                cmp++; if (!$onehot(bus.req_ready)) begin errs++; $display("FAIL rr_onehot got %b want one-hot", bus.req_ready); end
                for (int i = 0; i < N; i++) if (bus.req_ready[i]) begin
                    order[g] = i;
                    q_id.push_back(i);
                    q_dig.push_back(exp_dig(i));
                end
                g++;
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
                cmp++;
                if (q_id.size() == 0) begin
                    errs++; $display("FAIL rr_rsp got id=%0d want no response", bus.rsp_id);
                end else begin
                    if (bus.rsp_id !== IDW'(q_id[0]) || bus.rsp_digest !== q_dig[0]) begin
                        errs++; $display("FAIL rr_rsp got id=%0d dig=%h want id=%0d dig=%h", bus.rsp_id, bus.rsp_digest, q_id[0], q_dig[0]);
                    end
                    void'(q_id.pop_front());
                    void'(q_dig.pop_front());
                end
                r++;
            end
            @(negedge clk);
        end
        cmp++; if (g != 5 || r != 5) begin errs++; $display("FAIL rr_count got grants=%0d rsps=%0d want 5 5", g, r); end
        for (int j = 0; j < g; j++) begin
            cmp++; if (order[j] != j % N) begin errs++; $display("FAIL rr_order[%0d] got %0d want %0d", j, order[j], j % N); end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        bit got;
        int bad = 0;
        logic [159:0] exp;
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        wait_ready(got);
        cmp++; if (!got || bus.req_ready !== 4'b0010) begin errs++; $display("FAIL bp_grant got %b want 0010", bus.req_ready); end
        exp = exp_dig(1);
        @(negedge clk);
        bus.req_valid = 4'b1010;
        wait_rsp(got);
        cmp++; if (!got) begin errs++; $display("FAIL bp_rsp got no rsp_valid want rsp_valid within 200 cycles"); end
        for (int t = 0; t < 50; t++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_digest !== exp || bus.req_ready !== '0 || busy !== 1'b1) bad++;
            @(negedge clk); #1;
        end
        cmp++; if (bad != 0) begin errs++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b1000) begin
            errs++; $display("FAIL bp_next_grant got valid=%b ready=%b want valid=0 ready=1000", bus.rsp_valid, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        int q_id[$];
        logic [159:0] q_dig[$];
        int last = N - 1;
        bit outst = 1'b0;
        int idx, j;
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if (t >= 2800) begin
                bus.req_valid = '0;
                bus.rsp_ready = 1'b1;
            end else begin
                if ($urandom_range(0, 3) == 0) bus.req_valid = N'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    j = $urandom_range(0, N - 1);
                    bus.req_data[j*512 +: 512] = rnd512();
                end
                bus.rsp_ready = $urandom_range(0, 2) != 0;
            end
            #1;
            exp_rdy = '0;
            idx = -1;
            if (!outst) for (int k = 1; k <= N; k++) if (idx < 0 && bus.req_valid[(last + k) % N]) idx = (last + k) % N;
            if (idx >= 0) exp_rdy[idx] = 1'b1;
            cmp++; if (bus.req_ready !== exp_rdy) begin errs++; $display("FAIL rand_ready cycle %0d got %b want %b", t, bus.req_ready, exp_rdy); end
            if (idx >= 0) begin
                outst = 1'b1;
                last = idx;
                q_id.push_back(idx);
                q_dig.push_back(exp_dig(idx));
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
                cmp++;
                if (q_id.size() == 0) begin
                    errs++; $display("FAIL rand_rsp cycle %0d got id=%0d want no response", t, bus.rsp_id);
                end else begin
                    if (bus.rsp_id !== IDW'(q_id[0]) || bus.rsp_digest !== q_dig[0] || bus.rsp_error !== 1'b0) begin
                        errs++; $display("FAIL rand_rsp cycle %0d got id=%0d dig=%h err=%b want id=%0d dig=%h err=0", t, bus.rsp_id, bus.rsp_digest, bus.rsp_error, q_id[0], q_dig[0]);
                    end
                    void'(q_id.pop_front());
                    void'(q_dig.pop_front());
                end
                outst = 1'b0;
            end
            @(negedge clk);
        end
        cmp++; if (q_id.size() != 0) begin errs++; $display("FAIL rand_drain got %0d outstanding want 0", q_id.size()); end
    endtask

    task automatic test_reset_mid_run();
        bit got;
        int n = 0;
        int bad = 0;
        logic [159:0] exp;
        do_reset();
        bus.req_valid = 4'b0100;
        wait_ready(got);
        cmp++; if (!got || bus.req_ready !== 4'b0100) begin errs++; $display("FAIL midrst_grant got %b want 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        cmp++; if (core_on !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL midrst_clear got on=%b valid=%b busy=%b want 0 0 0", core_on, bus.rsp_valid, busy);
        end
        reset = 1'b0;
        bus.req_valid = 4'b0101;
        #1;
        cmp++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL midrst_first got %b want 0001", bus.req_ready); end
        exp = exp_dig(0);
        @(negedge clk);
        bus.req_valid = '0;
        for (int t = 0; t < 80; t++) begin
            #1;
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
                n++;
                if (bus.rsp_id !== 2'd0 || bus.rsp_digest !== exp) bad++;
            end
            @(negedge clk);
        end
        cmp++; if (n != 1 || bad != 0) begin errs++; $display("FAIL midrst_rsp got rsps=%0d wrong=%0d want 1 0", n, bad); end
    endtask

`ifdef SHA1_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit got;
        int bad = 0;
        logic [159:0] exp;
        do_reset();
        hang = 1'b1;
        bus.req_valid = 4'b0001;
        wait_ready(got);
        cmp++; if (!got || bus.req_ready !== 4'b0001) begin errs++; $display("FAIL to_grant got %b want 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        for (int k = 0; k < 64; k++) begin
            if (core_on !== 1'b1 || core_rst !== 1'b0) bad++;
            @(negedge clk); #1;
        end
        cmp++; if (bad != 0) begin errs++; $display("FAIL to_hold got %0d bad RUN cycles want 0", bad); end
        cmp++; if (core_on !== 1'b0 || core_rst !== 1'b1) begin errs++; $display("FAIL to_abort got on=%b rst=%b want 0 1", core_on, core_rst); end
        @(negedge clk); #1;
        cmp++; if (core_rst !== 1'b0) begin errs++; $display("FAIL to_pulse got rst=%b want 0", core_rst); end
        hang = 1'b0;
        wait_rsp(got);
        cmp++; if (!got || bus.rsp_error !== 1'b1 || bus.rsp_digest !== '0 || bus.rsp_id !== 2'd0) begin
            errs++; $display("FAIL to_rsp got err=%b dig=%h id=%0d want err=1 dig=0 id=0", bus.rsp_error, bus.rsp_digest, bus.rsp_id);
        end
        @(negedge clk);
        bus.req_valid = 4'b0010;
        wait_ready(got);
        cmp++; if (!got || bus.req_ready !== 4'b0010) begin errs++; $display("FAIL to_next_grant got %b want 0010", bus.req_ready); end
        exp = exp_dig(1);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(got);
        cmp++; if (!got || bus.rsp_error !== 1'b0 || bus.rsp_digest !== exp || bus.rsp_id !== 2'd1) begin
            errs++; $display("FAIL to_next_rsp got err=%b dig=%h id=%0d want err=0 dig=%h id=1", bus.rsp_error, bus.rsp_digest, bus.rsp_id, exp);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_mid_run();
`ifdef SHA1_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/sha1_arbiter.md
Name: sha1_arbiter

Overview:
Round-robin front-end that shares one sha1 core among NUM_REQ requesters. It accepts one 512-bit block at a time, holds the block stable on the core input, and sequences the core's on/finish protocol. It captures the 160-bit digest and returns it with the requester ID over a valid/ready response channel. It sits between the block producers and the sha1 core instance, and is the only driver of the core's on, message_in and reset.

Parameters:
NUM_REQ, 4, number of requesters (2..8); ID width IDW = $clog2(NUM_REQ), minimum 1.
DRAIN_CYCLES, 2, cycles core_on is held low after finish before the response is presented (min 2).
TIMEOUT_CYCLES, 1023, RUN-state cycle budget before the job is aborted (only with SHA1_ARB_TIMEOUT_EN).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester block valid
req_data  in  NUM_REQ*512  flattened blocks; requester i at [i*512 +: 512]
req_ready  out  NUM_REQ  one-hot accept; at most one bit high per cycle
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  requester index of the response
rsp_digest  out  160  captured digest {h0,h1,h2,h3,h4}
rsp_error  out  1  job aborted by timeout; rsp_digest is 0 in that case
core_rst  out  1  reset to the core = reset OR internal abort pulse
core_on  out  1  core on
core_msg  out  512  core message_in (registered block)
core_digest  in  160  core digest_out
core_finish  in  1  core finish
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_digest=0, rsp_error=0, core_on=0, core_msg=0, busy=0, rr_ptr=NUM_REQ-1.
- States: IDLE, RUN, DRAIN, RESP.
- IDLE, arbitration (combinational):
  - Grant the first i with req_valid[i], searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[grant]=1 only in IDLE; the transfer occurs on that edge.
- IDLE, on transfer:
  - core_msg <= req_data[grant]; id_reg <= grant; rr_ptr <= grant.
  - core_on <= 1; timer <= 0; state <= RUN.
- RUN:
  - core_on held 1 and core_msg held stable.
  - On core_finish=1: digest_reg <= core_digest, err <= 0, core_on <= 0, drain count <= 0, state <= DRAIN.
  - core_finish is ignored in every other state.
- DRAIN:
  - core_on=0 for exactly DRAIN_CYCLES cycles, so the core observes on low and returns to its init state.
  - Then rsp_valid <= 1 with rsp_id=id_reg, rsp_digest=digest_reg, rsp_error=err; state <= RESP.
- RESP:
  - Outputs held stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, state <= IDLE.
  - The next grant occurs no earlier than the following cycle (IDLE).
- Latency: accept edge to core_on high is 1 cycle. Core finish to rsp_valid is DRAIN_CYCLES+1 cycles.
- Fairness: a requester holding req_valid is granted within NUM_REQ grants. A requester may drop req_valid before it is granted, with no side effect.
- Simultaneous requests: the one nearest after rr_ptr wins; the others see req_ready=0.
- Reset mid-operation:
  - All state returns to reset values; any in-flight job is discarded with no response.
  - core_rst is high throughout reset.
- Only req_ready, busy and the core_rst OR term are combinational. Everything else is registered.

Optional Feature:
SHA1_ARB_TIMEOUT_EN
- Defined:
  - timer increments each RUN cycle.
  - If timer reaches TIMEOUT_CYCLES-1 with core_finish=0: core_on <= 0, core_rst pulses high for 1 cycle, digest_reg <= 0, err <= 1, state <= DRAIN.
  - This recovers a core stuck in its panic state.
  - core_finish in the same cycle as the expiry wins: normal completion.
- Undefined: no timer logic, RUN waits indefinitely, rsp_error tied 0, core_rst = reset.

Test Plan:
- Bench uses a core stub: finish rises 20 cycles after on and clears 1 cycle after on falls; digest = {5{msg[31:0]}}.
- Single job: req_valid=4'b0001, block[31:0]=32'h12345678 -> req_ready=4'b0001 for 1 cycle; core_on high 1 cycle later; rsp_valid 3 cycles after finish with rsp_id=0, rsp_digest={5{32'h12345678}}, rsp_error=0.
- Round robin: all four requesters valid continuously after reset -> grant order 0,1,2,3,0; each response carries the matching rsp_id.
- Backpressure: rsp_ready=0 for 50 cycles -> rsp_valid, rsp_id and rsp_digest stay stable; req_ready stays 0; the next grant comes 1 cycle after the handshake.
- Timeout (macro on, TIMEOUT_CYCLES=64, stub never finishes) -> at RUN cycle 63: core_on falls, core_rst 1-cycle pulse; then rsp_error=1, rsp_digest=0; the next request completes normally.
- Reset mid-RUN (cycle 10 of a job) -> core_on=0, rsp_valid=0, busy=0 the next cycle; no response for the aborted job; rr_ptr restarts so requester 0 wins first.
